// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// A start pulse in IDLE/DONE captures the operands; done rises WIDTH+1 edges later.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH:0]   part_reg, part_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // The dividend register doubles as the quotient shift register: each
  // iteration consumes its MSB and appends the new quotient bit at the LSB.
  always_comb begin
    state_next = state_reg;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    part_next  = part_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    done_next  = done_reg;
    busy_next  = busy_reg;
    dbz_next   = dbz_reg;

    shifted = {part_reg, dvd_reg[WIDTH-1]};
    trial   = shifted - {2'b00, dvs_reg};

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          dvd_next   = dividend;
          dvs_next   = divisor;
          part_next  = '0;
          cnt_next   = '0;
          done_next  = 1'b0;
          dbz_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == LAST) begin
          quo_next   = dvd_reg;
          rem_next   = part_reg[WIDTH-1:0];
          done_next  = 1'b1;
          busy_next  = 1'b0;
          dbz_next   = (dvs_reg == '0);
          state_next = DONE;
        end else begin
          // Sign bit of the widened trial decides restore versus keep.
          part_next = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          dvd_next  = {dvd_reg[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt_next  = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      part_reg  <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dvd_reg   <= dvd_next;
      dvs_reg   <= dvs_next;
      part_reg  <= part_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider: results, latency, start handling
// and reset behaviour.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;
  logic       busy;
  logic       div_by_zero;

  int pass_cnt;
  int total_cnt;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; returns 1 time unit after the accepting edge with
  // operands scrambled so a design that does not capture them is exposed.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom_range(0, 255));
    divisor  = 8'($urandom_range(0, 255));
  endtask

  // Count edges until done is seen high (sampled 1 unit after each edge).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic test_reset;
    int n;
    #2;
    total_cnt++;
    if ({quotient, remainder, done, busy, div_by_zero} !== 19'd0)
      $display("FAIL reset_init: q=%0d r=%0d done=%b busy=%b dbz=%b, required all 0",
               quotient, remainder, done, busy, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    start_op(8'd20, 8'd4);
    wait_done(n);
    total_cnt++;
    if (done !== 1'b1 || quotient !== 8'd5)
      $display("FAIL reset_pre_op: done=%b q=%0d, required done=1 q=5", done, quotient);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({quotient, remainder, done, busy, div_by_zero} !== 19'd0)
      $display("FAIL reset_async: q=%0d r=%0d done=%b busy=%b dbz=%b, required all 0",
               quotient, remainder, done, busy, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: done=%b busy=%b, required 0 0", done, busy);
    else pass_cnt++;
    $display("reset test complete");
  endtask

  task automatic test_basic;
    logic [7:0] va [4] = '{8'd20, 8'd25, 8'd5,  8'd15};
    logic [7:0] vb [4] = '{8'd4,  8'd4,  8'd10, 8'd1};
    logic [7:0] eq [4] = '{8'd5,  8'd6,  8'd0,  8'd15};
    logic [7:0] er [4] = '{8'd0,  8'd1,  8'd5,  8'd0};
    logic [7:0] prev_q;
    int n;
    prev_q = 8'd0;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0 || quotient !== prev_q)
        $display("FAIL basic_busy[%0d]: busy=%b done=%b q=%0d, required 1 0 %0d",
                 i, busy, done, quotient, prev_q);
      else pass_cnt++;
      wait_done(n);
      total_cnt++;
      if (n !== 9 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0)
        $display("FAIL basic[%0d]: %0d/%0d gave q=%0d r=%0d dbz=%b after %0d edges, required q=%0d r=%0d dbz=0 after 9",
                 i, va[i], vb[i], quotient, remainder, div_by_zero, n, eq[i], er[i]);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (done !== 1'b1 || quotient !== eq[i] || remainder !== er[i])
        $display("FAIL basic_hold[%0d]: done=%b q=%0d r=%0d, required 1 %0d %0d",
                 i, done, quotient, remainder, eq[i], er[i]);
      else pass_cnt++;
      $display("basic %0d/%0d -> q=%0d r=%0d latency=%0d", va[i], vb[i], quotient, remainder, n);
      prev_q = eq[i];
    end
  endtask

  task automatic test_boundaries;
    logic [7:0] va [4] = '{8'd255, 8'd255, 8'd0, 8'd200};
    logic [7:0] vb [4] = '{8'd255, 8'd1,   8'd7, 8'd0};
    logic [7:0] eq [4] = '{8'd1,   8'd255, 8'd0, 8'd255};
    logic [7:0] er [4] = '{8'd0,   8'd0,   8'd0, 8'd200};
    logic       ez [4] = '{1'b0,   1'b0,   1'b0, 1'b1};
    int n;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      wait_done(n);
      total_cnt++;
      if (n !== 9 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== ez[i])
        $display("FAIL bound[%0d]: %0d/%0d gave q=%0d r=%0d dbz=%b after %0d edges, required q=%0d r=%0d dbz=%b after 9",
                 i, va[i], vb[i], quotient, remainder, div_by_zero, n, eq[i], er[i], ez[i]);
      else pass_cnt++;
      $display("boundary %0d/%0d -> q=%0d r=%0d dbz=%b", va[i], vb[i], quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_held;
    int n;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd20;
    divisor  = 8'd4;
    @(posedge clk);
    #1;
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd5 || div_by_zero !== 1'b0)
      $display("FAIL held_first: q=%0d dbz=%b after %0d edges, required q=5 dbz=0 after 9",
               quotient, div_by_zero, n);
    else pass_cnt++;
    @(posedge clk);
    #1;
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL held_reaccept: done=%b busy=%b, required 0 1", done, busy);
    else pass_cnt++;
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd5 || remainder !== 8'd0)
      $display("FAIL held_second: q=%0d r=%0d after %0d edges, required q=5 r=0 after 9",
               quotient, remainder, n);
    else pass_cnt++;
    $display("start held: re-accepted once after done, q=%0d", quotient);
  endtask

  task automatic test_start_during_busy;
    int n;
    start_op(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    total_cnt++;
    if (n + 4 !== 9 || quotient !== 8'd14 || remainder !== 8'd2)
      $display("FAIL busy_start: q=%0d r=%0d after %0d edges, required q=14 r=2 after 9",
               quotient, remainder, n + 4);
    else pass_cnt++;
    $display("start during busy: 100/7 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_mid_op;
    int n;
    logic seen;
    start_op(8'd50, 8'd5);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midreset_abort: busy=%b done=%b, required 0 0", busy, done);
    else pass_cnt++;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0)
      $display("FAIL midreset_nodone: done seen=%b, required 0", seen);
    else pass_cnt++;
    start_op(8'd50, 8'd5);
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd10 || remainder !== 8'd0)
      $display("FAIL midreset_fresh: q=%0d r=%0d after %0d edges, required q=10 r=0 after 9",
               quotient, remainder, n);
    else pass_cnt++;
    $display("reset mid-op: fresh 50/5 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_random;
    logic [7:0] a, b, exp_q, exp_r;
    int n;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      exp_q = a / b;
      exp_r = a % b;
      start_op(a, b);
      wait_done(n);
      total_cnt++;
      if (n !== 9 || quotient !== exp_q || remainder !== exp_r) begin
        $display("FAIL random[%0d]: %0d/%0d gave q=%0d r=%0d after %0d edges, required q=%0d r=%0d after 9",
                 i, a, b, quotient, remainder, n, exp_q, exp_r);
        bad++;
      end else pass_cnt++;
    end
    $display("random: 1000 divisions, %0d wrong", bad);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    start     = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    test_reset;
    test_basic;
    test_boundaries;
    test_start_held;
    test_start_during_busy;
    test_reset_mid_op;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider: computes quotient = dividend / divisor and remainder = dividend % divisor with a restoring shift-subtract algorithm, one quotient bit per clock.
- Sits as a shared arithmetic slave: a controller pulses start with operands, waits for done, then reads the registered results.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a division; sampled on the rising edge, accepted only in IDLE or DONE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- quotient  output  WIDTH  registered quotient; valid while done=1.
- remainder  output  WIDTH  registered remainder; valid while done=1.
- done  output  1  result-valid flag.
- busy  output  1  high while a division is in progress.
- div_by_zero  output  1  high with done when the captured divisor was 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; quotient, remainder, done, busy and div_by_zero all 0; internal registers cleared. Reset mid-operation aborts the division, and no done is produced.
- States: IDLE, BUSY, DONE.
- IDLE or DONE, start=1 at an edge:
  - Capture dividend and divisor into internal registers.
  - Clear partial remainder (WIDTH+1 bits) and the iteration counter.
  - Clear done and div_by_zero; set busy; go to BUSY.
  - Inputs may change freely after this edge.
- IDLE or DONE, start=0: hold state and outputs.
- BUSY: exactly WIDTH iterations, one per edge, MSB of dividend first. Each iteration:
  - Shift the partial remainder left by 1, inserting the next dividend bit.
  - Compute trial = partial - divisor, zero-extended to WIDTH+1 bits.
  - If trial is non-negative, the partial remainder becomes trial and the quotient bit is 1; otherwise the partial remainder is kept and the quotient bit is 0.
- After the WIDTH-th iteration edge, at the next edge:
  - Load quotient and remainder outputs (low WIDTH bits of the partial remainder).
  - Set done=1 and busy=0; set div_by_zero if the captured divisor was 0; go to DONE.
- Latency: start accepted at edge N gives done=1 after edge N+WIDTH+1 (9 cycles for WIDTH=8).
- DONE: done, quotient, remainder and div_by_zero stay stable until the next accepted start or reset.
- The quotient/remainder outputs keep their previous values throughout BUSY; only done indicates validity.
- start while BUSY is ignored, with no restart and no effect on the result.
- start held high for several cycles: accepted once. Re-acceptance is possible only after done, so a start still high at the done edge is not re-sampled that cycle. Re-acceptance happens from DONE at the next edge where start=1.
- Divide by zero follows the natural algorithm result: quotient = all ones (255 for WIDTH=8), remainder = dividend, div_by_zero=1, same latency.
- Invariant for divisor≠0: quotient*divisor + remainder = dividend, remainder < divisor.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; release, idle with done=0.
- Sequence of 1-cycle start pulses, waiting for done before each read:
  - 20/4 -> quotient 5, remainder 0.
  - 25/4 -> quotient 6, remainder 1.
  - 5/10 -> quotient 0, remainder 5.
  - 15/1 -> quotient 15, remainder 0.
  - Each: done rises exactly 9 edges after the start edge and stays high until the next start.
- Boundaries:
  - 255/255 -> quotient 1, remainder 0.
  - 255/1 -> quotient 255, remainder 0.
  - 0/7 -> quotient 0, remainder 0.
  - 200/0 -> quotient 255, remainder 200, div_by_zero=1.
- Start during BUSY: start 100/7, pulse start with 9/3 at cycle 4 -> result is still quotient 14, remainder 2 at the original done time.
- Reset mid-operation: start 50/5, assert rst at cycle 3 -> done never rises. A fresh 50/5 then gives quotient 10, remainder 0.
- Random: 1000 random operand pairs, divisor≠0 -> quotient and remainder match the reference integer division; operands changed right after the start edge do not corrupt results.
